// File: rtl/mem_port_ctrl.sv
// mem_port_ctrl: LC-3 memory-port unit. Owns MAR/MDR and turns a one-cycle request
// into a multi-cycle asynchronous-SRAM read or write with WAIT_STATES extra cycles,
// finishing with a one-cycle mem_ack.
//
// Optional feature: define MEM_IO_MAP_EN to map addresses >= IO_BASE onto io_sw
// (read) and io_hex (write) instead of the SRAM.
//
// Ports:
//   clk, Reset            clock, asynchronous active-high reset
//   bus_in                internal bus value
//   LD_MAR, LD_MDR        register loads from bus_in (honoured only while idle)
//   mem_req, mem_we       access request and direction (sampled only while idle)
//   mem_ack, busy         completion pulse, not-idle flag
//   MAR_out, MDR_out      register contents
//   sram_*                SRAM address/data and active-low strobes
//   io_sw, io_hex         switch input / hex display register (MEM_IO_MAP_EN only)
module mem_port_ctrl #(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned AWIDTH      = 16,
    parameter int unsigned WAIT_STATES = 2
`ifdef MEM_IO_MAP_EN
    ,
    parameter logic [AWIDTH-1:0] IO_BASE = AWIDTH'(16'hFE00)
`endif
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic [WIDTH-1:0]  bus_in,
    input  logic              LD_MAR,
    input  logic              LD_MDR,
    input  logic              mem_req,
    input  logic              mem_we,
    output logic              mem_ack,
    output logic              busy,
    output logic [AWIDTH-1:0] MAR_out,
    output logic [WIDTH-1:0]  MDR_out,
    output logic [AWIDTH-1:0] sram_addr,
    output logic [WIDTH-1:0]  sram_wdata,
    input  logic [WIDTH-1:0]  sram_rdata,
`ifdef MEM_IO_MAP_EN
    input  logic [WIDTH-1:0]  io_sw,
    output logic [WIDTH-1:0]  io_hex,
`endif
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n
);

    localparam logic [3:0] WaitInit = 4'(WAIT_STATES);

    typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

    state_e             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               we_q, we_d;
    logic [AWIDTH-1:0]  mar_q, mar_d;
    logic [WIDTH-1:0]   mdr_q, mdr_d;
    logic               bypass;
`ifdef MEM_IO_MAP_EN
    logic               io_q, io_d;
    logic [WIDTH-1:0]   hex_q, hex_d;
`endif

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            mar_q   <= '0;
            mdr_q   <= '0;
`ifdef MEM_IO_MAP_EN
            io_q    <= 1'b0;
            hex_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            mar_q   <= mar_d;
            mdr_q   <= mdr_d;
`ifdef MEM_IO_MAP_EN
            io_q    <= io_d;
            hex_q   <= hex_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        mar_d   = mar_q;
        mdr_d   = mdr_q;
`ifdef MEM_IO_MAP_EN
        io_d    = io_q;
        hex_d   = hex_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (LD_MAR) mar_d = AWIDTH'(bus_in);
                if (LD_MDR) mdr_d = bus_in;
                if (mem_req) begin
                    // The access uses MAR/MDR as loaded on this same edge.
                    state_d = StAccess;
                    we_d    = mem_we;
                    cnt_d   = WaitInit;
`ifdef MEM_IO_MAP_EN
                    io_d    = (mar_d >= IO_BASE);
                    if (io_d) cnt_d = 4'd0;
`endif
                end
            end
            StAccess: begin
                if (cnt_q == 4'd0) begin
                    state_d = StDone;
`ifdef MEM_IO_MAP_EN
                    if (!we_q) mdr_d = io_q ? io_sw : sram_rdata;
                    else if (io_q) hex_d = mdr_q;
`else
                    if (!we_q) mdr_d = sram_rdata;
`endif
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

`ifdef MEM_IO_MAP_EN
    assign bypass = io_q;
    assign io_hex = hex_q;
`else
    assign bypass = 1'b0;
`endif

    logic sram_cyc;
    assign sram_cyc = (state_q == StAccess) && !bypass;

    // Strobes derive from the async-reset state, so they drop to 1 the moment Reset rises.
    // The last write cycle releases we_n to hold data; with no wait states that cycle is
    // the only one, so we_n stays low then.
    assign sram_ce_n = !sram_cyc;
    assign sram_oe_n = !(sram_cyc && !we_q);
    assign sram_we_n = !(sram_cyc && we_q && ((cnt_q != 4'd0) || (WAIT_STATES == 0)));

    assign mem_ack    = (state_q == StDone);
    assign busy       = (state_q != StIdle);
    assign MAR_out    = mar_q;
    assign MDR_out    = mdr_q;
    assign sram_addr  = mar_q;
    assign sram_wdata = mdr_q;

endmodule

// File: tb/tb_mem_port_ctrl.sv
// Self-checking bench for mem_port_ctrl (default parameters, WAIT_STATES = 2).
// A cycle-count model predicts every output each cycle; directed tests add literal checks.
module tb_mem_port_ctrl;

    localparam int W = 2;

    logic        clk = 1'b0;
    logic        Reset = 1'b1;
    logic [15:0] bus_in = '0;
    logic        LD_MAR = 1'b0, LD_MDR = 1'b0, mem_req = 1'b0, mem_we = 1'b0;
    logic        mem_ack, busy;
    logic [15:0] MAR_out, MDR_out, sram_addr, sram_wdata, sram_rdata;
    logic [15:0] io_sw = '0;
    logic [15:0] io_hex;
    logic        sram_ce_n, sram_oe_n, sram_we_n;

    always #5 clk = ~clk;

    mem_port_ctrl dut (
        .clk        (clk),
        .Reset      (Reset),
        .bus_in     (bus_in),
        .LD_MAR     (LD_MAR),
        .LD_MDR     (LD_MDR),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_ack    (mem_ack),
        .busy       (busy),
        .MAR_out    (MAR_out),
        .MDR_out    (MDR_out),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata),
`ifdef MEM_IO_MAP_EN
        .io_sw      (io_sw),
        .io_hex     (io_hex),
`endif
        .sram_ce_n  (sram_ce_n),
        .sram_oe_n  (sram_oe_n),
        .sram_we_n  (sram_we_n)
    );

`ifndef MEM_IO_MAP_EN
    assign io_hex = '0;
`endif

    // SRAM: 256 words, indexed by the low address byte.
    logic [15:0] sram [0:255];
    assign sram_rdata = sram[sram_addr[7:0]];
    initial begin
        for (int i = 0; i < 256; i++) sram[i] = 16'h0000;
        forever begin
            @(posedge clk);
            if (!sram_ce_n && !sram_we_n) sram[sram_addr[7:0]] = sram_wdata;
        end
    end

    int n_checks = 0;
    int n_errors = 0;
    int ack_cnt  = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: m_left counts remaining busy cycles (access cycles then one ack cycle).
    int          m_left = 0;
    logic [15:0] m_mar = '0, m_mdr = '0, m_hex = '0;
    logic        m_we = 1'b0, m_io = 1'b0;

    initial begin
        forever begin
            @(posedge clk or posedge Reset);
            if (Reset) begin
                m_left = 0; m_mar = '0; m_mdr = '0; m_hex = '0; m_we = 1'b0; m_io = 1'b0;
            end else if (m_left == 0) begin
                if (LD_MAR) m_mar = bus_in;
                if (LD_MDR) m_mdr = bus_in;
                if (mem_req) begin
                    m_we = mem_we;
`ifdef MEM_IO_MAP_EN
                    m_io = (m_mar >= 16'hFE00);
`else
                    m_io = 1'b0;
`endif
                    m_left = m_io ? 2 : W + 2;
                end
            end else begin
                if (m_left == 2) begin
                    if (!m_we) m_mdr = m_io ? io_sw : sram[m_mar[7:0]];
                    else if (m_io) m_hex = m_mdr;
                end
                m_left--;
            end
        end
    end

    always @(negedge clk) begin
        logic acc;
        if (mem_ack) ack_cnt++;
        if (chk_en && !Reset) begin
            acc = (m_left > 1) && !m_io;
            check("busy", busy, m_left > 0);
            check("mem_ack", mem_ack, m_left == 1);
            check("ce_n", sram_ce_n, !acc);
            check("oe_n", sram_oe_n, !(acc && !m_we));
            check("we_n", sram_we_n, !(acc && m_we && (m_left > 2 || W == 0)));
            check("MAR_out", MAR_out, m_mar);
            check("MDR_out", MDR_out, m_mdr);
            check("sram_addr", sram_addr, m_mar);
            check("sram_wdata", sram_wdata, m_mdr);
`ifdef MEM_IO_MAP_EN
            check("io_hex", io_hex, m_hex);
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits for mem_ack (bounded); n = 1 is the cycle right after the accepting edge.
    task automatic run_access(output int lat, output int oe_lo, output int we_lo,
                              output int str_lo, output logic we3, output logic [15:0] mdr);
        lat = 0; oe_lo = 0; we_lo = 0; str_lo = 0; we3 = 1'b1; mdr = '0;
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            if (!sram_oe_n) oe_lo++;
            if (!sram_we_n) we_lo++;
            if (!sram_ce_n || !sram_oe_n || !sram_we_n) str_lo++;
            if (n == 3) we3 = sram_we_n;
            if (mem_ack) begin
                lat = n;
                mdr = MDR_out;
                break;
            end
        end
        if (lat == 0) check("ack_timeout", 0, 1);
        tick();
    endtask

    int          lat, oe_lo, we_lo, str_lo, a0;
    logic        we3;
    logic [15:0] mdr;

    initial begin
        sram[8'h00] = 16'hBEEF;  // address 16'h3000
        tick(); tick();
        check("rst_MAR", MAR_out, 16'h0000);
        check("rst_MDR", MDR_out, 16'h0000);
        check("rst_busy", busy, 0);
        check("rst_ack", mem_ack, 0);
        check("rst_strobes", {sram_ce_n, sram_oe_n, sram_we_n}, 3'b111);
        Reset = 1'b0;
        chk_en = 1'b1;
        tick();

        // Read 16'h3000
        bus_in = 16'h3000; LD_MAR = 1'b1; tick();
        LD_MAR = 1'b0; mem_req = 1'b1; mem_we = 1'b0; tick();
        mem_req = 1'b0;
        run_access(lat, oe_lo, we_lo, str_lo, we3, mdr);
        check("rd_latency", lat, 4);
        check("rd_oe_cycles", oe_lo, 3);
        check("rd_mdr", mdr, 16'hBEEF);

        // Write 16'h1234 to 16'h0042, MAR loaded on the request edge
        bus_in = 16'h1234; LD_MDR = 1'b1; tick();
        LD_MDR = 1'b0; bus_in = 16'h0042; LD_MAR = 1'b1; mem_req = 1'b1; mem_we = 1'b1;
        a0 = ack_cnt;
        tick();
        LD_MAR = 1'b0; mem_req = 1'b0; mem_we = 1'b0;
        run_access(lat, oe_lo, we_lo, str_lo, we3, mdr);
        check("wr_latency", lat, 4);
        check("wr_we_cycles", we_lo, 2);
        check("wr_we_hold", we3, 1);
        check("wr_oe_cycles", oe_lo, 0);
        check("wr_sram", sram[8'h42], 16'h1234);
        tick();
        check("wr_ack_count", ack_cnt - a0, 1);

        // Busy lockout: read 0x0042 while loads and a second request arrive mid-access
        a0 = ack_cnt;
        mem_req = 1'b1; mem_we = 1'b0; tick();
        bus_in = 16'hFFFF; LD_MAR = 1'b1; LD_MDR = 1'b1; tick();
        LD_MAR = 1'b0; LD_MDR = 1'b0; mem_req = 1'b0;
        run_access(lat, oe_lo, we_lo, str_lo, we3, mdr);
        check("lock_mdr", mdr, 16'h1234);
        tick(); tick(); tick();
        check("lock_MAR", MAR_out, 16'h0042);
        check("lock_ack_count", ack_cnt - a0, 1);

        // mem_req held high: period W+3, so 10 edges give two accesses
        a0 = ack_cnt;
        mem_req = 1'b1;
        repeat (10) tick();
        mem_req = 1'b0;
        repeat (3) tick();
        check("held_ack_count", ack_cnt - a0, 2);

        // Reset in the 2nd ACCESS cycle of a write
        bus_in = 16'h5555; LD_MDR = 1'b1; tick();
        LD_MDR = 1'b0; bus_in = 16'h0010; LD_MAR = 1'b1; mem_req = 1'b1; mem_we = 1'b1; tick();
        LD_MAR = 1'b0; mem_req = 1'b0; mem_we = 1'b0; tick();
        check("rstw_we_low", sram_we_n, 0);
        a0 = ack_cnt;
        #2 Reset = 1'b1;
        #1;
        check("rstw_we_n", sram_we_n, 1);
        check("rstw_ce_n", sram_ce_n, 1);
        check("rstw_busy", busy, 0);
        check("rstw_ack", mem_ack, 0);
        check("rstw_MAR", MAR_out, 16'h0000);
        check("rstw_MDR", MDR_out, 16'h0000);
        tick();
        Reset = 1'b0;
        repeat (6) tick();
        check("rstw_no_ack", ack_cnt - a0, 0);

        // Normal read after the interrupted write
        bus_in = 16'h3000; LD_MAR = 1'b1; mem_req = 1'b1; tick();
        LD_MAR = 1'b0; mem_req = 1'b0;
        run_access(lat, oe_lo, we_lo, str_lo, we3, mdr);
        check("post_latency", lat, 4);
        check("post_mdr", mdr, 16'hBEEF);

`ifdef MEM_IO_MAP_EN
        bus_in = 16'h00A5; LD_MDR = 1'b1; tick();
        LD_MDR = 1'b0; bus_in = 16'hFE10; LD_MAR = 1'b1; mem_req = 1'b1; mem_we = 1'b1; tick();
        LD_MAR = 1'b0; mem_req = 1'b0; mem_we = 1'b0;
        run_access(lat, oe_lo, we_lo, str_lo, we3, mdr);
        check("io_wr_latency", lat, 2);
        check("io_wr_strobes", str_lo, 0);
        check("io_hex_val", io_hex, 16'h00A5);

        io_sw = 16'h0F0F;
        bus_in = 16'hFE00; LD_MAR = 1'b1; mem_req = 1'b1; tick();
        LD_MAR = 1'b0; mem_req = 1'b0;
        run_access(lat, oe_lo, we_lo, str_lo, we3, mdr);
        check("io_rd_latency", lat, 2);
        check("io_rd_strobes", str_lo, 0);
        check("io_rd_mdr", mdr, 16'h0F0F);
`endif

        repeat (2) tick();
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
